// File: rtl/game_pkg.sv
// Shared game-logic types and constants: FSM encoding, character box geometry, score increment.
// SCORE_BCD_EN selects a three-digit BCD score instead of a binary one.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } game_state_e;

    localparam int CHAR_W     = 16;
    localparam int CHAR_H     = 16;
    localparam int CRAWL_W    = 32;
    localparam int CRAWL_YOFF = 8;
    localparam int CRAWL_H    = 8;
    localparam int SCORE_MAX  = 999;

    // Saturating score increment; the top stops at 999 in either representation.
    function automatic logic [11:0] score_inc(input logic [11:0] s);
        logic [11:0] r;
`ifdef SCORE_BCD_EN
        if (s == 12'h999)
            r = s;
        else if (s[3:0] != 4'd9)
            r = {s[11:8], s[7:4], s[3:0] + 4'd1};
        else if (s[7:4] != 4'd9)
            r = {s[11:8], s[7:4] + 4'd1, 4'd0};
        else
            r = {s[11:8] + 4'd1, 8'd0};
`else
        if (s == 12'(SCORE_MAX))
            r = s;
        else
            r = s + 12'd1;
`endif
        return r;
    endfunction

endpackage

// File: rtl/collision_scorer_if.sv
// Signal bundle between the renderer/obstacle mover and the collision scorer.
// Protocol: ob_valid qualifies ob_x/ob_y every cycle, ob_spawn and start are one-cycle pulses; no backpressure.
interface collision_scorer_if;
    logic        start;
    logic [7:0]  char_x;
    logic [6:0]  char_y;
    logic        crawl;
    logic [7:0]  ob_x;
    logic [6:0]  ob_y;
    logic        ob_valid;
    logic        ob_spawn;
    logic        hit;
    logic [1:0]  lives;
    logic [11:0] score;
    logic [1:0]  state;
    logic        freeze;

    modport master (
        output start, char_x, char_y, crawl, ob_x, ob_y, ob_valid, ob_spawn,
        input  hit, lives, score, state, freeze
    );

    modport slave (
        input  start, char_x, char_y, crawl, ob_x, ob_y, ob_valid, ob_spawn,
        output hit, lives, score, state, freeze
    );
endinterface

// File: rtl/rect_overlap.sv
// Registered intersection test of two axis-aligned rectangles with inclusive edges.
// Bounds arrive pre-widened so the caller decides how sums avoid wrap-around.
module rect_overlap #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [XW-1:0] a_x0_i,
    input  logic [XW-1:0] a_x1_i,
    input  logic [YW-1:0] a_y0_i,
    input  logic [YW-1:0] a_y1_i,
    input  logic [XW-1:0] b_x0_i,
    input  logic [XW-1:0] b_x1_i,
    input  logic [YW-1:0] b_y0_i,
    input  logic [YW-1:0] b_y1_i,
    output logic          overlap_o
);
    logic overlap_q;
    logic overlap_d;

    assign overlap_d = (a_x0_i <= b_x1_i) && (b_x0_i <= a_x1_i) &&
                       (a_y0_i <= b_y1_i) && (b_y0_i <= a_y1_i);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) overlap_q <= 1'b0;
        else          overlap_q <= overlap_d;
    end

    assign overlap_o = overlap_q;
endmodule

// File: rtl/collision_scorer.sv
// Collision detection, lives/score bookkeeping and game-state FSM behind the character renderer.
// Build with SCORE_BCD_EN defined for a BCD score; otherwise the score is binary.
module collision_scorer
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int OB_W        = 8,
    parameter int OB_H        = 12
) (
    input  logic               clock,
    input  logic               reset_n,
    collision_scorer_if.slave  bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [8:0] cx0, cx1, ox0, ox1;
    logic [7:0] cy0, cy1, oy0, oy1;
    logic       pass_now, overlap_r;

    // x sums at 9 bits, y sums at 8 bits: nothing wraps.
    assign cx0 = {1'b0, bus.char_x};
    assign cx1 = cx0 + (bus.crawl ? 9'(CRAWL_W - 1) : 9'(CHAR_W - 1));
    assign cy0 = {1'b0, bus.char_y} + (bus.crawl ? 8'(CRAWL_YOFF) : 8'd0);
    assign cy1 = {1'b0, bus.char_y} + (bus.crawl ? 8'(CRAWL_YOFF + CRAWL_H - 1) : 8'(CHAR_H - 1));
    assign ox0 = {1'b0, bus.ob_x};
    assign ox1 = ox0 + 9'(OB_W - 1);
    assign oy0 = {1'b0, bus.ob_y};
    assign oy1 = oy0 + 8'(OB_H - 1);
    assign pass_now = (ox0 + 9'(OB_W)) <= cx0;

    rect_overlap #(.XW(9), .YW(8)) u_overlap (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_x0_i    (cx0),
        .a_x1_i    (cx1),
        .a_y0_i    (cy0),
        .a_y1_i    (cy1),
        .b_x0_i    (ox0),
        .b_x1_i    (ox1),
        .b_y0_i    (oy0),
        .b_y1_i    (oy1),
        .overlap_o (overlap_r)
    );

    // Qualifiers ride in the same pipeline stage as overlap_r so every compare sees one input sample.
    logic valid_q, spawn_q, pass_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            spawn_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            valid_q <= bus.ob_valid;
            spawn_q <= bus.ob_spawn;
            pass_q  <= pass_now;
        end
    end

    game_state_e   state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [11:0]   score_q, score_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          counted_q, counted_d, scored_q, scored_d;
    logic          hit_q, hit_d, freeze_q;
    logic          coll, pass_ok;

    assign coll    = overlap_r & valid_q & ~counted_q & ~spawn_q;
    assign pass_ok = pass_q & valid_q & ~counted_q & ~scored_q & ~spawn_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lives_q   <= 2'd0;
            score_q   <= 12'd0;
            hold_q    <= '0;
            counted_q <= 1'b0;
            scored_q  <= 1'b0;
            hit_q     <= 1'b0;
            freeze_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            hold_q    <= hold_d;
            counted_q <= counted_d;
            scored_q  <= scored_d;
            hit_q     <= hit_d;
            freeze_q  <= (state_d == IDLE) || (state_d == OVER);
        end
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        hold_d    = hold_q;
        hit_d     = 1'b0;
        counted_d = counted_q & ~spawn_q;
        scored_d  = scored_q & ~spawn_q;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d   = RUN;
                    lives_d   = 2'(LIVES);
                    score_d   = 12'd0;
                    hold_d    = '0;
                    counted_d = 1'b0;
                    scored_d  = 1'b0;
                end
            end
            RUN: begin
                if (coll) begin
                    hit_d     = 1'b1;
                    counted_d = 1'b1;
                    lives_d   = lives_q - 2'd1;
                    hold_d    = '0;
                    state_d   = (lives_q == 2'd1) ? OVER : HOLD;
                end else if (pass_ok) begin
                    scored_d = 1'b1;
                    score_d  = score_inc(score_q);
                end
            end
            HOLD: begin
                if (pass_ok) begin
                    scored_d = 1'b1;
                    score_d  = score_inc(score_q);
                end
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.hit    = hit_q;
        bus.lives  = lives_q;
        bus.score  = score_q;
        bus.state  = state_q;
        bus.freeze = freeze_q;
    end
endmodule

// File: doc/collision_scorer.md
# collision_scorer

Game-logic stage directly downstream of the character renderer. It consumes the character's top-left position and crawl posture, together with the current obstacle's position. It detects bounding-box overlap, counts lives and score, and drives a game-state FSM whose `freeze` output halts the renderer and obstacle mover on game over.

## Interface
Parameters:
- `LIVES`, 3 — lives loaded on start (1..3).
- `HOLD_CYCLES`, 25_000_000 — invulnerability window after a non-fatal hit, in clocks.
- `OB_W`, 8 — obstacle width in pixels.
- `OB_H`, 12 — obstacle height in pixels.

Ports:
- `clock` in 1 — system clock.
- `reset_n` in 1 — reset; asynchronous, active-low.
- `start` in 1 — one-cycle pulse that begins or restarts a game.
- `char_x` in 8 — character left edge.
- `char_y` in 7 — character top edge, standing posture.
- `crawl` in 1 — 1 selects the crawling bounding box.
- `ob_x` in 8 — obstacle left edge.
- `ob_y` in 7 — obstacle top edge.
- `ob_valid` in 1 — obstacle is on screen.
- `ob_spawn` in 1 — one-cycle pulse marking a new obstacle.
- `hit` out 1 — one-cycle pulse on each counted collision.
- `lives` out 2 — remaining lives.
- `score` out 12 — obstacles cleared.
- `state` out 2 — current FSM state, encoded as in the package.
- `freeze` out 1 — high in IDLE and OVER.

## Operation
- **Bounding boxes**
  - Standing: x in [char_x, char_x+15], y in [char_y, char_y+15].
  - Crawling: x in [char_x, char_x+31], y in [char_y+8, char_y+15].
  - Obstacle: x in [ob_x, ob_x+OB_W-1], y in [ob_y, ob_y+OB_H-1].
- **Arithmetic**
  - All x sums are computed at 9 bits and all y sums at 8 bits, so there is no wrap-around.
  - Overlap is strict interval intersection on both axes, with inclusive edges.
- **Per-obstacle flags**: `counted` and `scored`, both cleared by `ob_spawn`.
- **FSM states**: IDLE, RUN, HOLD, OVER.
  - IDLE
    - `start` → RUN.
    - On entry to RUN: lives=LIVES, score=0, both flags cleared.
  - RUN, collision: if `overlap_r` & `ob_valid` & !`counted`:
    - pulse `hit`, set `counted`, lives-1.
    - If the new lives value is 0 → OVER; otherwise → HOLD.
  - RUN, pass: if `ob_valid` & !`counted` & !`scored` & (ob_x+OB_W <= char_x):
    - set `scored`, score+1, saturating at 999.
  - HOLD
    - A hold counter runs HOLD_CYCLES clocks; then → RUN.
    - Overlaps in HOLD are ignored and do not set `counted`.
    - Passes are still scored.
  - OVER
    - Holds lives=0 and the final score.
    - `start` → RUN with a full reload.
- **Simultaneous events**
  - `ob_spawn` in the same cycle as a collision or pass: the spawn wins, the flags clear, and that cycle's compare is discarded.
  - `start` in RUN or HOLD: ignored.
  - Collision and pass qualifying in the same cycle: the collision wins and no score is given.
- **Reset mid-operation**: all state returns to reset values immediately, regardless of the FSM state.

## Timing
- **Reset values**: state=IDLE, hit=0, lives=0, score=0, freeze=1, all flags=0, hold counter=0.
- **Overlap pipeline**: `overlap_r` is registered from the inputs sampled at edge N.
- **Latency**: FSM, `hit`, `lives` and `score` update at edge N+1, i.e. 2 clocks from the input change to the visible output.
- **Pulse width**: `hit` is high for exactly one clock per counted collision.
- **HOLD duration**: exactly HOLD_CYCLES clocks from entry to RUN re-entry.
- **`freeze`**: a registered decode of the next state, so it aligns with `state`.

## Configuration
- `SCORE_BCD_EN` defined:
  - `score` is three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] ones.
  - Increment uses decimal carry and saturates at 12'h999.
- `SCORE_BCD_EN` undefined:
  - `score` is plain binary, zero-extended.
  - Saturates at 12'd999.

## Structure
- **Shared package `game_pkg`**:
  - FSM state encoding: IDLE=0, RUN=1, HOLD=2, OVER=3.
  - Character box constants: CHAR_W=16, CHAR_H=16, CRAWL_W=32, CRAWL_YOFF=8, CRAWL_H=8.
  - Score saturation constant: 999.
- **Sub-module `rect_overlap`**: registered two-rectangle intersection, producing `overlap_r`. It is reused later for projectile checks.

## Test plan
- **Reset and start**: reset_n low then high → state=IDLE, freeze=1. Pulse `start` → RUN, lives=3, score=0.
- **Standing overlap**: char (20,75), ob (30,80), ob_valid=1 → hit pulses 2 clocks later, lives=2, state=HOLD. After HOLD_CYCLES (use 16) → RUN.
- **Crawl clears high obstacle**: crawl=1, char (20,75), ob (30,60) → no hit. Move ob_x down to 10 → score=1 exactly once while ob_x stays ≤ 12. `ob_spawn` re-arms scoring.
- **Game over**: three separate spawned colliding obstacles → lives 2,1,0, state=OVER, freeze=1. `start` → RUN with lives=3, score=0.
- **Saturation**: force score to 999, then clear one more obstacle → score stays 999 (12'h999 with SCORE_BCD_EN, 12'd999 without).
- **Simultaneous events**: `ob_spawn` in the same cycle as an overlap → no hit. Assert reset_n mid-HOLD → immediate IDLE, all outputs at reset values.
